// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns and encodings for the time display
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {PAGE_HHMM = 1'b0, PAGE_MMSS = 1'b1} page_e;
  typedef enum logic {FIELD_MIN = 1'b0, FIELD_HOUR = 1'b1} field_e;
endpackage

// File: rtl/seg7_time_display_bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a} pattern, dash for 10-15
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  // table lookup; non-BCD codes show a dash
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_time_display.sv
// seg7_time_display: multiplexed 4-digit 7-segment driver for the BCD time bus
module seg7_time_display
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLINK_TICKS = 50_000_000,
  parameter bit SUPPRESS_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic       page_sel,
  input  logic       edit_en,
  input  logic       edit_pos,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int TW = DIGIT_TICKS > 1 ? $clog2(DIGIT_TICKS) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam int SW = $clog2(NUM_DIGITS);

  logic [TW-1:0] r_tick;
  logic [SW-1:0] r_scan;
  logic [BW-1:0] r_blink;
  logic          r_phase, r_edit_q;
  logic [3:0]    r_h2, r_h1, r_m2, r_m1, r_s2, r_s1;
  page_e         r_page;

  logic          w_tick_wrap, w_frame_end, w_blink_wrap, w_edit_rise;
  logic          w_in_field, w_blank;
  logic [3:0]    w_digit;
  logic [6:0]    w_pat;

  assign w_tick_wrap  = r_tick == TW'(DIGIT_TICKS - 1);
  assign w_frame_end  = w_tick_wrap && r_scan == SW'(NUM_DIGITS - 1);
  assign w_blink_wrap = r_blink == BW'(BLINK_TICKS - 1);
  assign w_edit_rise  = edit_en && !r_edit_q;

  // digit dwell timer and scan position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_scan <= '0;
    end else begin
      r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
      r_scan <= w_tick_wrap ? r_scan + 1'b1 : r_scan;
    end
  end

  // frame-boundary snapshot so a frame never mixes old and new digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_h2, r_h1, r_m2, r_m1, r_s2, r_s1} <= '0;
      r_page <= PAGE_HHMM;
    end else if (w_frame_end) begin
      {r_h2, r_h1, r_m2, r_m1, r_s2, r_s1} <= {h2, h1, m2, m1, s2, s1};
      r_page <= page_e'(page_sel);
    end
  end

  // free-running blink phase, restarted visible when editing begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink  <= '0;
      r_phase  <= 1'b1;
      r_edit_q <= 1'b0;
    end else begin
      r_edit_q <= edit_en;
      r_blink  <= (w_edit_rise || w_blink_wrap) ? '0 : r_blink + 1'b1;
      r_phase  <= w_edit_rise ? 1'b1 : w_blink_wrap ? ~r_phase : r_phase;
    end
  end

  // select the snapshot digit for the current scan slot and decide blanking
  always_comb begin
    w_digit = r_page == PAGE_MMSS ?
              (r_scan == 2'd3 ? r_m2 : r_scan == 2'd2 ? r_m1 : r_scan == 2'd1 ? r_s2 : r_s1) :
              (r_scan == 2'd3 ? r_h2 : r_scan == 2'd2 ? r_h1 : r_scan == 2'd1 ? r_m2 : r_m1);
    w_in_field = r_page == PAGE_HHMM ? (r_scan[1] == edit_pos) :
                 (r_scan[1] && edit_pos == FIELD_MIN);
    w_blank = (edit_en && !r_phase && w_in_field) ||
              (SUPPRESS_LZ && r_scan == 2'd3 && w_digit == 4'd0);
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_pat)
  );

  // registered pin drivers so anode, cathodes and dot switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_scan);
      seg <= w_blank ? SEG_BLANK : w_pat;
      dp  <= !(r_scan == 2'd2 && r_phase);
    end
  end
endmodule

// File: tb/tb_seg7_time_display.sv
// tb_seg7_time_display: scoreboard bench for the multiplexed time display
module tb_seg7_time_display;
  localparam int DT = 4;
  localparam int BT = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] h2 = 4'd1, h1 = 4'd2, m2 = 4'd3, m1 = 4'd0, s2 = 4'd5, s1 = 4'd9;
  logic page_sel = 1'b0, edit_en = 1'b0, edit_pos = 1'b0;
  logic [3:0] an, an_lz;
  logic [6:0] seg, seg_lz;
  logic dp, dp_lz;
  int n_tests = 0, n_fail = 0;

  logic [23:0] q[$];
  logic [23:0] e;
  int m_tick = 0, m_scan = 0, m_blink = 0;
  bit m_phase = 1'b1, m_edit_q = 1'b0, m_page = 1'b0;
  logic [3:0] m_d[6];

  always #5 clk = ~clk;

  seg7_time_display #(.DIGIT_TICKS(DT), .BLINK_TICKS(BT), .SUPPRESS_LZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .page_sel(page_sel), .edit_en(edit_en), .edit_pos(edit_pos), .an(an), .seg(seg), .dp(dp));

  seg7_time_display #(.DIGIT_TICKS(DT), .BLINK_TICKS(BT), .SUPPRESS_LZ(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .page_sel(page_sel), .edit_en(edit_en), .edit_pos(edit_pos), .an(an_lz), .seg(seg_lz), .dp(dp_lz));

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // p = display position from the left; fields: 0 minutes, 1 hours, 2 seconds
  function automatic logic [11:0] model(input bit lz);
    int p, f;
    logic [3:0] d;
    bit blank;
    p = 3 - m_scan;
    d = m_d[(m_page ? 2 : 0) + p];
    f = m_page ? (p < 2 ? 0 : 2) : (p < 2 ? 1 : 0);
    blank = (edit_en && !m_phase && f == int'(edit_pos)) || (lz && p == 0 && d == 4'd0);
    return {~(4'b0001 << m_scan), blank ? 7'h7f : pat(d), ~(m_scan == 2 && m_phase)};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // reference model: expected pins after each edge go into the scoreboard
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tick <= 0; m_scan <= 0; m_blink <= 0;
      m_phase <= 1'b1; m_edit_q <= 1'b0; m_page <= 1'b0;
      for (int i = 0; i < 6; i++) m_d[i] <= 4'd0;
      q.delete();
    end else begin
      q.push_back({model(1'b0), model(1'b1)});
      m_edit_q <= edit_en;
      if (edit_en && !m_edit_q) begin
        m_blink <= 0; m_phase <= 1'b1;
      end else if (m_blink == BT - 1) begin
        m_blink <= 0; m_phase <= !m_phase;
      end else m_blink <= m_blink + 1;
      if (m_tick == DT - 1) begin
        m_tick <= 0;
        m_scan <= (m_scan + 1) % 4;
        if (m_scan == 3) begin
          m_d[0] <= h2; m_d[1] <= h1; m_d[2] <= m2;
          m_d[3] <= m1; m_d[4] <= s2; m_d[5] <= s1;
          m_page <= page_sel;
        end
      end else m_tick <= m_tick + 1;
    end
  end

  // scoreboard drain, away from the active edge
  always @(negedge clk) begin
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("scan", {an, seg, dp}, e[23:12]);
      check("scan_lz", {an_lz, seg_lz, dp_lz}, e[11:0]);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_digit(input string tag, input bit lz, input logic [3:0] a, input logic [6:0] s);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((lz ? an_lz : an) == a) begin
        check(tag, {5'd0, lz ? seg_lz : seg}, {5'd0, s});
        return;
      end
    end
    n_tests++;
    n_fail++;
    $error("FAIL %s: anode %b never seen within 40 cycles", tag, a);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check("rst", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1 check("first_an", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
    run(40);
    wait_digit("idx1_m2", 1'b0, 4'b1101, 7'b0110000);
    wait_digit("idx2_h1", 1'b0, 4'b1011, 7'b0100100);
    wait_digit("idx3_h2", 1'b0, 4'b0111, 7'b1111001);
    run(6);
    page_sel = 1'b1;
    run(40);
    wait_digit("pg1_idx0", 1'b0, 4'b1110, 7'b0010000);
    wait_digit("pg1_idx1", 1'b0, 4'b1101, 7'b0010010);
    page_sel = 1'b0;
    edit_en = 1'b1;
    edit_pos = 1'b1;
    run(100);
    page_sel = 1'b1;
    run(80);
    edit_pos = 1'b0;
    run(80);
    edit_en = 1'b0;
    run(10);
    edit_en = 1'b1;
    run(45);
    edit_en = 1'b0;
    page_sel = 1'b0;
    m1 = 4'hC;
    run(40);
    wait_digit("dash", 1'b0, 4'b1110, 7'b0111111);
    h2 = 4'd0;
    run(40);
    wait_digit("lz_blank", 1'b1, 4'b0111, 7'b1111111);
    wait_digit("no_lz", 1'b0, 4'b0111, 7'b1000000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
    check("async_rst_lz", {an_lz, seg_lz, dp_lz}, {4'b1111, 7'b1111111, 1'b1});
    run(3);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1 check("resume", {8'd0, an}, {8'd0, 4'b1110});
    run(30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
